// File: rtl/dw_sequencer_if.sv
// Operand/result bus for dw_sequencer.
// Handshake: a transfer happens on a rising edge where valid && ready; the sender holds data stable while valid && !ready.
interface dw_sequencer_if #(
   parameter int N = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] v;
   logic [N-1:0] w;
   logic [N-1:0] step;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] dw;
   logic         busy;

   modport master (
      output in_valid, a, b, v, w, step, out_ready,
      input  in_ready, out_valid, dw, busy
   );

   modport slave (
      input  in_valid, a, b, v, w, step, out_ready,
      output in_ready, out_valid, dw, busy
   );
endinterface

// File: rtl/dw_sequencer.sv
// Izhikevich recovery update dw = a*((b*v)-w)*step with one shared fixed-point multiplier.
// Define DW_SAT_EN to clamp multiply/subtract results instead of wrapping.
module dw_sequencer #(
   parameter int N = 32,
   parameter int Q = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   dw_sequencer_if.slave  bus,
   output logic [2:0]     o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_MUL_BV   = 3'd1,
      S_SUB_W    = 3'd2,
      S_MUL_A    = 3'd3,
      S_MUL_STEP = 3'd4,
      S_OUT      = 3'd5
   } state_t;

`ifdef DW_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   localparam logic [N-1:0] MAX_VAL = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

   state_t r_state, w_next;

   logic [N-1:0] r_a, r_b, r_v, r_w, r_step, r_t, r_dw;

   logic [N-1:0]          w_mx, w_my;
   logic signed [2*N-1:0] w_mx_ext, w_my_ext, w_prod, w_shr;
   logic                  w_mul_ovf;
   logic [N-1:0]          w_mul_res;
   logic [N:0]            w_diff;
   logic                  w_sub_ovf;
   logic [N-1:0]          w_sub_res;

   always_comb begin
      w_mx = '0;
      w_my = '0;
      case (r_state)
         S_MUL_BV:   begin w_mx = r_b; w_my = r_v;    end
         S_MUL_A:    begin w_mx = r_a; w_my = r_t;    end
         S_MUL_STEP: begin w_mx = r_t; w_my = r_step; end
         default:    ;
      endcase
   end

   // Arithmetic shift of the full product gives floor rounding; the top N+1 bits must agree to fit in N.
   assign w_mx_ext  = {{N{w_mx[N-1]}}, w_mx};
   assign w_my_ext  = {{N{w_my[N-1]}}, w_my};
   assign w_prod    = w_mx_ext * w_my_ext;
   assign w_shr     = w_prod >>> Q;
   assign w_mul_ovf = !((&w_shr[2*N-1:N-1]) || !(|w_shr[2*N-1:N-1]));
   assign w_mul_res = (SAT && w_mul_ovf) ? (w_shr[2*N-1] ? MIN_VAL : MAX_VAL) : w_shr[N-1:0];

   assign w_diff    = {r_t[N-1], r_t} - {r_w[N-1], r_w};
   assign w_sub_ovf = w_diff[N] ^ w_diff[N-1];
   assign w_sub_res = (SAT && w_sub_ovf) ? (w_diff[N] ? MIN_VAL : MAX_VAL) : w_diff[N-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (bus.in_valid) w_next = S_MUL_BV;
         S_MUL_BV:   w_next = S_SUB_W;
         S_SUB_W:    w_next = S_MUL_A;
         S_MUL_A:    w_next = S_MUL_STEP;
         S_MUL_STEP: w_next = S_OUT;
         S_OUT:      if (bus.out_ready) w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_v    <= '0;
         r_w    <= '0;
         r_step <= '0;
         r_t    <= '0;
         r_dw   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_a    <= bus.a;
                  r_b    <= bus.b;
                  r_v    <= bus.v;
                  r_w    <= bus.w;
                  r_step <= bus.step;
               end
            end
            S_MUL_BV:   r_t  <= w_mul_res;
            S_SUB_W:    r_t  <= w_sub_res;
            S_MUL_A:    r_t  <= w_mul_res;
            S_MUL_STEP: r_dw <= w_mul_res;
            default:    ;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = (r_state == S_OUT);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.dw        = r_dw;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_dw_sequencer.sv
// Self-checking bench for dw_sequencer: vector table, random ops vs a fixed-point model, corner sequences.
// Honours DW_SAT_EN for the expected values.
module tb_dw_sequencer;
   localparam int N = 32;
   localparam int Q = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] dbg_state;

   dw_sequencer_if #(.N(N)) bus();

   dw_sequencer #(.N(N), .Q(Q)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   logic [N-1:0] exp_q[$];

   typedef struct {
      logic [N-1:0] a, b, v, w, s, exp;
      string        name;
   } vec_t;
   vec_t vecs[5];

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Reference: real-valued rules with floor division and clamp/wrap to N bits.
   function automatic logic [N-1:0] fit(input longint r);
`ifdef DW_SAT_EN
      if (r > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
      if (r < -64'sh80000000) return 32'h80000000;
`endif
      return r[N-1:0];
   endfunction

   function automatic logic [N-1:0] fmul(input logic signed [N-1:0] x, input logic signed [N-1:0] y);
      longint p, q;
      p = longint'(x) * longint'(y);
      q = p / 65536;
      if (p < 0 && (p % 65536) != 0) q = q - 1;
      return fit(q);
   endfunction

   function automatic logic [N-1:0] model(input logic [N-1:0] a, b, v, w, s);
      logic signed [N-1:0] t;
      t = fmul(b, v);
      t = fit(longint'(t) - longint'($signed(w)));
      t = fmul(a, t);
      return fmul(t, s);
   endfunction

   function automatic logic [N-1:0] rnd_op();
      if ($urandom_range(0, 3) == 0) return $urandom;
      return 32'($urandom_range(0, 32'h80000)) - 32'h40000;
   endfunction

   task automatic scramble();
      bus.a = $urandom; bus.b = $urandom; bus.v = $urandom; bus.w = $urandom; bus.step = $urandom;
   endtask

   // Drives one operand set from IDLE through the output handshake; call at a falling edge.
   task automatic do_op(input logic [N-1:0] a, b, v, w, s, exp, input string name);
      int k;
      bus.a = a; bus.b = b; bus.v = v; bus.w = w; bus.step = s;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b0;
      k = 0;
      while (!bus.in_ready && k < 20) begin @(negedge clk); k++; end
      chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      scramble();
      chk({name, "_busy"}, 32'(bus.busy), 32'd1);
      chk({name, "_not_ready"}, 32'(bus.in_ready), 32'd0);
      k = 0;
      while (!bus.out_valid && k < 20) begin @(negedge clk); scramble(); k++; end
      // Accepting edge counts as the first, so out_valid appears four edges later.
      chk({name, "_latency"}, 32'(k), 32'd4);
      chk({name, "_dw"}, bus.dw, exp);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({name, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
      chk({name, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
      chk({name, "_dw_held"}, bus.dw, exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, last, nres;
      logic [N-1:0] dw_ref, exp_sat;

`ifdef DW_SAT_EN
      exp_sat = 32'h7FFFFFFF;
`else
      exp_sat = 32'hFFF00000;
`endif
      vecs[0] = '{32'h00010000, 32'h00020000, 32'h00030000, 32'h00010000, 32'h00008000, 32'h00028000, "basic"};
      vecs[1] = '{32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 32'h00008000, 32'hFFFFFFFF, "floor"};
      vecs[2] = '{32'h00010000, 32'h7FFF0000, 32'h00100000, 32'h00000000, 32'h00010000, exp_sat,      "ovf"};
      vecs[3] = '{32'h00020000, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00010000, 32'h00020000, "two"};
      vecs[4] = '{32'hFFFF0000, 32'h00010000, 32'h00030000, 32'h00010000, 32'h00010000, 32'hFFFE0000, "neg"};

      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.v = '0; bus.w = '0; bus.step = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_dw", bus.dw, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++)
         do_op(vecs[i].a, vecs[i].b, vecs[i].v, vecs[i].w, vecs[i].s, vecs[i].exp, vecs[i].name);

      for (int i = 0; i < 16; i++) begin
         logic [N-1:0] ra, rb, rv, rw, rs;
         ra = rnd_op(); rb = rnd_op(); rv = rnd_op(); rw = rnd_op(); rs = rnd_op();
         do_op(ra, rb, rv, rw, rs, model(ra, rb, rv, rw, rs), "rand");
      end

      // Backpressure in OUT with in_valid held high and inputs changing.
      bus.a = 32'h00010000; bus.b = 32'h00020000; bus.v = 32'h00030000;
      bus.w = 32'h00010000; bus.step = 32'h00008000;
      bus.in_valid = 1'b1;
      @(negedge clk);
      k = 0;
      while (!bus.out_valid && k < 20) begin scramble(); @(negedge clk); k++; end
      chk("bp_latency", 32'(k), 32'd4);
      for (int i = 0; i < 10; i++) begin
         scramble();
         @(negedge clk);
         chk("bp_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_dw", bus.dw, 32'h00028000);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
      chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
      chk("bp_dw_held", bus.dw, 32'h00028000);

      // Reset while the third stage is active.
      bus.a = 32'h00020000; bus.b = 32'h00010000; bus.v = 32'h00010000;
      bus.w = 32'h00000000; bus.step = 32'h00010000;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_dw", bus.dw, 32'd0);
      chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
      chk("mid_busy_low", 32'(bus.busy), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("mid_no_output", 32'(bus.out_valid), 32'd0);
      end
      do_op(vecs[0].a, vecs[0].b, vecs[0].v, vecs[0].w, vecs[0].s, 32'h00028000, "post_rst");

      // Back-to-back with in_valid and out_ready held high.
      bus.out_ready = 1'b1;
      last = -1;
      nres = 0;
      for (int c = 0; c < 60; c++) begin
         if (bus.out_valid) begin
            if (exp_q.size() == 0) chk("b2b_spurious", 32'(bus.out_valid), 32'd0);
            else chk("b2b_dw", bus.dw, exp_q.pop_front());
            if (last >= 0) chk("b2b_interval", 32'(c - last), 32'd6);
            last = c;
            nres++;
         end
         bus.a = rnd_op(); bus.b = rnd_op(); bus.v = rnd_op(); bus.w = rnd_op(); bus.step = rnd_op();
         bus.in_valid = (c < 48);
         if (bus.in_valid && bus.in_ready) begin
            dw_ref = model(bus.a, bus.b, bus.v, bus.w, bus.step);
            exp_q.push_back(dw_ref);
         end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      chk("b2b_drained", 32'(exp_q.size()), 32'd0);
      chk("b2b_count", 32'(nres), 32'd8);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
